// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_ctrl_if: Avalon-MM slave port bundle for uart_rx_ctrl         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface uart_rx_ctrl_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_ctrl: UART receive sequencer - oversample clock, frame       |
// | capture into a receive FIFO, sticky status and interrupt.  Rev 1.0   |
// +----------------------------------------------------------------------+
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 27
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_rx_ctrl_if.slave avs,
  output logic          irq,
  output logic          rx_sample_clk,
  input  logic [8:0]    rx_frame,
  input  logic          rx_load
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DIVISOR = 2'd3;

  // registered state
  logic [2:0]       ctrl_q,    ctrl_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sclk_q,    sclk_d;
  logic [1:0]       sync_q,    sync_d;
  logic             edge_q,    edge_d;
  logic             cap_q,     cap_d;
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             ovr_q,     ovr_d;
  logic             ferr_q,    ferr_d;
  logic [31:0]      rdata_q,   rdata_d;
  logic             irq_q,     irq_d;

  logic [8:0]       mem_q [FIFO_DEPTH];

  // decoded control
  logic             wr_data, wr_status, wr_control, wr_divisor, rd_data;
  logic             empty, full, flush, pop, cap_ok, push, drop;
  logic [DIV_W-1:0] div_eff;
  logic [7:0]       count_rd;
  logic             unused_wdata;

  assign wr_data      = avs.avs_write && (avs.avs_address == ADDR_DATA);
  assign wr_status    = avs.avs_write && (avs.avs_address == ADDR_STATUS);
  assign wr_control   = avs.avs_write && (avs.avs_address == ADDR_CONTROL);
  assign wr_divisor   = avs.avs_write && (avs.avs_address == ADDR_DIVISOR);
  assign rd_data      = avs.avs_read  && (avs.avs_address == ADDR_DATA);
  assign unused_wdata = ^{avs.avs_writedata, wr_data};

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign flush    = wr_control && avs.avs_writedata[3];
  assign pop      = rd_data && !empty;
  // A capture landing in a flush cycle is thrown away with the old contents.
  assign cap_ok   = cap_q && ctrl_q[0] && !flush;
  assign push     = cap_ok && (!full || pop);
  assign drop     = cap_ok && full && !pop;
  assign div_eff  = (div_q == '0) ? DIV_W'(1) : div_q;
  assign count_rd = 8'(count_q);

  // Oversample clock divider
  always_comb begin
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    if (wr_divisor) begin
      div_d     = avs.avs_writedata[DIV_W-1:0];
      div_cnt_d = '0;
      sclk_d    = 1'b0;
    end else if (div_cnt_q == div_eff - DIV_W'(1)) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // rx_load crosses from the sample-clock domain; cap is one clk wide
  always_comb begin
    sync_d = {sync_q[0], rx_load};
    edge_d = sync_q[1];
    cap_d  = sync_q[1] && !edge_q;
  end

  // FIFO pointers, count and control register
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    if (wr_control) begin
      ctrl_d = avs.avs_writedata[2:0];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky status: a new event in the same cycle as its W1C wins
  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr_status && avs.avs_writedata[2]) begin
      ovr_d = 1'b0;
    end
    if (wr_status && avs.avs_writedata[3]) begin
      ferr_d = 1'b0;
    end
    if (drop) begin
      ovr_d = 1'b1;
    end
    if (cap_ok && rx_frame[8]) begin
      ferr_d = 1'b1;
    end
  end

  // Read data and interrupt
  always_comb begin
    rdata_d = rdata_q;
    if (avs.avs_read) begin
      case (avs.avs_address)
        ADDR_DATA:    rdata_d = empty ? 32'd0 : {22'd0, 1'b1, mem_q[rd_ptr_q]};
        ADDR_STATUS:  rdata_d = {16'd0, count_rd, 4'd0, ferr_q, ovr_q, full, empty};
        ADDR_CONTROL: rdata_d = {29'd0, ctrl_q};
        default:      rdata_d = 32'(div_q);
      endcase
    end
    irq_d = (ctrl_q[1] && !empty) || (ctrl_q[2] && (ovr_q || ferr_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= '0;
      div_q     <= DIV_W'(DIV_RESET);
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sync_q    <= '0;
      edge_q    <= 1'b0;
      cap_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      sync_q    <= sync_d;
      edge_q    <= edge_d;
      cap_q     <= cap_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_frame;
    end
  end

  assign avs.avs_readdata = rdata_q;
  assign irq              = irq_q;
  assign rx_sample_clk    = sclk_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_ctrl: directed bench with a queue-based reference model.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_uart_rx_ctrl;
  localparam int DEPTH = 16;
  localparam int DIVR  = 27;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       irq, rx_sample_clk, rx_load;
  logic [8:0] rx_frame;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DIV_RESET(DIVR)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs           (bus.slave),
    .irq           (irq),
    .rx_sample_clk (rx_sample_clk),
    .rx_frame      (rx_frame),
    .rx_load       (rx_load)
  );

  always #5 clk = ~clk;

  // reference model
  logic [8:0]  q[$];
  logic        m_ovr, m_ferr;
  logic [2:0]  m_ctrl;
  logic [15:0] m_div;

  int          vectors = 0;
  int          fails   = 0;
  logic        busy    = 1'b1;
  logic [31:0] got;

  function automatic logic [31:0] m_status();
    return {16'd0, 8'(q.size()), 4'd0, m_ferr, m_ovr,
            q.size() == DEPTH, q.size() == 0};
  endfunction

  function automatic logic m_irq();
    return (m_ctrl[1] && q.size() != 0) || (m_ctrl[2] && (m_ovr || m_ferr));
  endfunction

  task automatic m_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_ctrl = 3'd0;
    m_div  = 16'(DIVR);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // irq is compared every cycle once the bus and receiver have been quiet
  task automatic compare_loop();
    int quiet = 0;
    forever begin
      @(negedge clk);
      if (busy || !reset_n) quiet = 0;
      else if (quiet < 2) quiet++;
      else chk("irq", {31'd0, irq}, {31'd0, m_irq()});
    end
  endtask

  task automatic model_cap(input logic [8:0] f);
    if (m_ctrl[0]) begin
      if (f[8]) m_ferr = 1'b1;
      if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(f);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    busy = 1'b1;
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
    case (a)
      2'd1: begin
        if (d[2]) m_ovr = 1'b0;
        if (d[3]) m_ferr = 1'b0;
      end
      2'd2: begin
        m_ctrl = d[2:0];
        if (d[3]) q.delete();
      end
      2'd3: m_div = d[15:0];
      default: ;
    endcase
    busy = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string nm, output logic [31:0] data);
    logic [31:0] exp;
    busy = 1'b1;
    case (a)
      2'd0: begin
        if (q.size() > 0) begin
          exp = {22'd0, 1'b1, q[0]};
          void'(q.pop_front());
        end else exp = 32'd0;
      end
      2'd1:    exp = m_status();
      2'd2:    exp = {29'd0, m_ctrl};
      default: exp = {16'd0, m_div};
    endcase
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    data = bus.avs_readdata;
    chk(nm, data, exp);
    busy = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] f);
    busy = 1'b1;
    rx_frame = f; rx_load = 1'b1;
    repeat (6) @(negedge clk);
    model_cap(f);
    rx_load = 1'b0;
    repeat (4) @(negedge clk);
    busy = 1'b0;
  endtask

  // Times a DATA read so that it lands in the same cycle as the capture
  task automatic frame_with_read(input logic [8:0] f, input string nm);
    logic [31:0] d;
    busy = 1'b1;
    rx_frame = f; rx_load = 1'b1;
    repeat (3) @(negedge clk);
    rd(2'd0, nm, d);
    busy = 1'b1;
    model_cap(f);
    repeat (2) @(negedge clk);
    rx_load = 1'b0;
    repeat (4) @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic period(input string nm, input int exp);
    int   r1 = -1;
    int   r2 = -1;
    logic prev;
    prev = rx_sample_clk;
    for (int i = 0; i < 200 && r2 < 0; i++) begin
      @(negedge clk);
      if (rx_sample_clk && !prev) begin
        if (r1 < 0) r1 = i;
        else r2 = i;
      end
      prev = rx_sample_clk;
    end
    chk(nm, 32'(r2 - r1), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b0;
    rx_load = 1'b0; rx_frame = 9'd0;
    bus.avs_address = 2'd0; bus.avs_read = 1'b0;
    bus.avs_write = 1'b0; bus.avs_writedata = 32'd0;
    m_reset();
    fork compare_loop(); join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.avs_readdata, 32'd0);
    chk("rst_irq",   {31'd0, irq}, 32'd0);
    chk("rst_sclk",  {31'd0, rx_sample_clk}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    rd(2'd1, "rst_status", got);  chk("rst_status_lit", got, 32'h1);
    rd(2'd3, "rst_div", got);     chk("rst_div_lit", got, 32'd27);
    rd(2'd2, "rst_ctrl", got);

    // basic capture
    wr(2'd3, 32'd4);
    chk("div_wr_low", {31'd0, rx_sample_clk}, 32'd0);
    period("period_d4", 8);
    wr(2'd2, 32'h3);
    send_frame(9'h041);
    chk("irq_data", {31'd0, irq}, 32'd1);
    rd(2'd1, "cap_status", got);  chk("cap_status_lit", got, 32'h100);
    rd(2'd0, "cap_data", got);    chk("cap_data_lit", got, 32'h241);
    rd(2'd0, "cap_empty", got);   chk("cap_empty_lit", got, 32'h0);

    // fill and overrun
    wr(2'd2, 32'h5);
    for (int i = 0; i <= 16; i++) send_frame(9'(i));
    rd(2'd1, "ovr_status", got);  chk("ovr_status_lit", got, 32'h1006);
    chk("irq_ovr", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 16; i++) rd(2'd0, "fill_data", got);
    chk("fill_last_lit", got, 32'h20F);
    wr(2'd1, 32'h4);
    rd(2'd1, "w1c_status", got);  chk("w1c_status_lit", got, 32'h1);

    // frame error
    send_frame(9'h1AA);
    rd(2'd1, "ferr_status", got); chk("ferr_status_lit", got, 32'h108);
    chk("irq_ferr", {31'd0, irq}, 32'd1);
    rd(2'd0, "ferr_data", got);   chk("ferr_data_lit", got, 32'h3AA);
    wr(2'd1, 32'h8);

    // push and pop together at full, after wrap-around
    wr(2'd2, 32'h1);
    for (int i = 0; i < 16; i++) send_frame(9'(32 + i));
    frame_with_read(9'h055, "pp_data");
    rd(2'd1, "pp_status", got);   chk("pp_status_lit", got, 32'h1002);
    for (int i = 0; i < 16; i++) rd(2'd0, "pp_drain", got);
    chk("pp_last_lit", got, 32'h255);

    // disable, flush, divisor change
    wr(2'd2, 32'h0);
    send_frame(9'h077);
    rd(2'd1, "dis_status", got);  chk("dis_status_lit", got, 32'h1);
    wr(2'd2, 32'h1);
    for (int i = 0; i < 5; i++) send_frame(9'(80 + i));
    rd(2'd1, "pre_flush", got);   chk("pre_flush_lit", got, 32'h500);
    wr(2'd2, 32'h9);
    rd(2'd1, "flush_status", got);
    rd(2'd2, "flush_ctrl", got);  chk("flush_ctrl_lit", got, 32'h1);
    wr(2'd3, 32'd0);
    chk("div0_low", {31'd0, rx_sample_clk}, 32'd0);
    period("period_d0", 2);

    // reset in the middle of a read
    wr(2'd2, 32'h3);
    for (int i = 0; i < 3; i++) send_frame(9'(100 + i));
    rd(2'd1, "mid_status", got);
    busy = 1'b1;
    bus.avs_address = 2'd0; bus.avs_read = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    bus.avs_read = 1'b0;
    chk("mid_rdata", bus.avs_readdata, 32'd0);
    chk("mid_irq",   {31'd0, irq}, 32'd0);
    chk("mid_sclk",  {31'd0, rx_sample_clk}, 32'd0);
    m_reset();
    reset_n = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    rd(2'd1, "post_status", got); chk("post_status_lit", got, 32'h1);
    rd(2'd3, "post_div", got);    chk("post_div_lit", got, 32'd27);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
`default_nettype wire
